// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the multiplexed display scanner.
// Holds FSM states, digit one-hot codes and default timing.
package module_display_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [3:0] DIG_U = 4'b0001;
    localparam logic [3:0] DIG_D = 4'b0010;
    localparam logic [3:0] DIG_C = 4'b0100;
    localparam logic [3:0] DIG_M = 4'b1000;

    localparam int DEF_REFRESH_DIV  = 27000;
    localparam int DEF_BLANK_CYCLES = 270;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // A digit stays visible unless it and every higher digit are zero.
    function automatic logic [3:0] lz_visible(
        input logic [15:0] v,
        input logic        lz
    );
        logic [3:0] vis;
        vis[0] = 1'b1;
        vis[1] = !lz || (v[15:4] != 12'h000);
        vis[2] = !lz || (v[15:8] != 8'h00);
        vis[3] = !lz || (v[15:12] != 4'h0);
        return vis;
    endfunction

endpackage

// File: rtl/module_display_scan_prescaler.sv
// Digit-slot counter: counts 0..DIV-1 while enabled.
// Clears to zero whenever disabled.
module module_prescaler #(
    parameter  int DIV = 8,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic last;

    assign last = (cnt == CW'(DIV - 1));
    assign wrap = en && last;

    // Slot counter with wrap at DIV-1 and clear when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/module_display_scan.sv
// Four-digit display scanner with dead-time, leading-zero
// blanking and frame-synchronous commit of the shown value.
module module_display_scan
    import module_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] cdu_in,
    input  logic        blank_lz,
    output logic [3:0]  sel,
    output logic [15:0] cdu_out,
    output logic [3:0]  an,
    output logic        pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          run;
    logic          frame;
    logic [15:0]   shadow;
    logic [3:0]    vis;

    // The slot counter only runs once the FSM has left IDLE, so
    // the first slot after enabling starts cleanly at zero.
    assign run   = en && (state != IDLE);
    assign frame = wrap && (sel == DIG_M);

    module_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: disable overrides everything.
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  state_nx = BLANK;
                BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) state_nx = SHOW;
                SHOW:  if (wrap) state_nx = BLANK;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Digit select rotates per slot and self-heals if corrupted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= DIG_U;
        end else if (!is_onehot(sel)) begin
            sel <= DIG_U;
        end else if (wrap) begin
            sel <= {sel[2:0], sel[3]};
        end
    end

    // Shadow capture and frame-boundary commit; a load on the
    // boundary edge wins over the clear of pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= 16'h0000;
            cdu_out <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (frame) begin
                cdu_out <= shadow;
            end
            if (load) begin
                shadow  <= cdu_in;
                pending <= 1'b1;
            end else if (frame) begin
                pending <= 1'b0;
            end
        end
    end

    assign vis = lz_visible(cdu_out, blank_lz);
    assign an  = (state == SHOW) ? ~(sel & vis) : 4'b1111;

endmodule

// File: tb/tb_module_display_scan.sv
// Directed bench for the display scanner (REFRESH_DIV=8,
// BLANK_CYCLES=2) with hand-computed expectations.
module tb_module_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] cdu_in;
    logic        blank_lz;
    logic [3:0]  sel;
    logic [15:0] cdu_out;
    logic [3:0]  an;
    logic        pending;

    int total = 0;
    int bad   = 0;

    module_display_scan #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .cdu_in   (cdu_in),
        .blank_lz (blank_lz),
        .sel      (sel),
        .cdu_out  (cdu_out),
        .an       (an),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        cdu_in   = 16'h0000;
        blank_lz = 1'b0;
        #2;
        chk("rst_sel", 32'(sel), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_cdu", 32'(cdu_out), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;

        for (int e = 0; e <= 186; e++) begin
            case (e)
                3:   begin load = 1'b1; cdu_in = 16'h1234; end
                38:  begin load = 1'b1; cdu_in = 16'h9999; end
                40:  begin load = 1'b1; cdu_in = 16'h0005; end
                64:  begin load = 1'b1; cdu_in = 16'h0042; end
                100: begin load = 1'b1; cdu_in = 16'h0070; end
                128: blank_lz = 1'b1;
                172: en = 1'b0;
                175: en = 1'b1;
                185: begin load = 1'b1; cdu_in = 16'h0999; end
                default: ;
            endcase
            step();
            load = 1'b0;
            case (e)
                0:   chk("e0_an", 32'(an), 32'hF);
                1:   begin
                         chk("e1_an", 32'(an), 32'hF);
                         chk("e1_sel", 32'(sel), 32'h1);
                     end
                2:   chk("e2_an", 32'(an), 32'hE);
                3:   chk("e3_pend", 32'(pending), 32'h1);
                7:   begin
                         chk("e7_an", 32'(an), 32'hE);
                         chk("e7_sel", 32'(sel), 32'h1);
                     end
                8:   begin
                         chk("e8_sel", 32'(sel), 32'h2);
                         chk("e8_an", 32'(an), 32'hF);
                     end
                10:  chk("e10_an", 32'(an), 32'hD);
                31:  begin
                         chk("e31_cdu", 32'(cdu_out), 32'h0);
                         chk("e31_pend", 32'(pending), 32'h1);
                     end
                32:  begin
                         chk("e32_sel", 32'(sel), 32'h1);
                         chk("e32_cdu", 32'(cdu_out), 32'h1234);
                         chk("e32_pend", 32'(pending), 32'h0);
                     end
                64:  begin
                         chk("e64_cdu", 32'(cdu_out), 32'h0005);
                         chk("e64_pend", 32'(pending), 32'h1);
                     end
                96:  begin
                         chk("e96_cdu", 32'(cdu_out), 32'h0042);
                         chk("e96_pend", 32'(pending), 32'h0);
                     end
                128: chk("e128_cdu", 32'(cdu_out), 32'h0070);
                133: chk("lz_units", 32'(an), 32'hE);
                141: chk("lz_tens", 32'(an), 32'hD);
                149: begin
                         chk("lz_hund", 32'(an), 32'hF);
                         chk("e149_sel", 32'(sel), 32'h4);
                     end
                157: begin
                         chk("lz_thou", 32'(an), 32'hF);
                         chk("e157_sel", 32'(sel), 32'h8);
                     end
                172: begin
                         chk("off_an", 32'(an), 32'hF);
                         chk("off_sel", 32'(sel), 32'h2);
                     end
                174: chk("off_hold", 32'(sel), 32'h2);
                175: chk("on_blank0", 32'(an), 32'hF);
                176: chk("on_blank1", 32'(an), 32'hF);
                177: chk("on_show", 32'(an), 32'hD);
                183: chk("on_wrap", 32'(sel), 32'h4);
                185: chk("mid_pend", 32'(pending), 32'h1);
                default: ;
            endcase
        end

        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel", 32'(sel), 32'h1);
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_cdu", 32'(cdu_out), 32'h0);
        chk("arst_pend", 32'(pending), 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int r = 0; r <= 32; r++) begin
            step();
            if (r == 0) chk("rel_an", 32'(an), 32'hF);
            if (r == 2) chk("rel_show", 32'(an), 32'hE);
            if (r == 32) begin
                chk("rel_sel", 32'(sel), 32'h1);
                chk("rel_cdu", 32'(cdu_out), 32'h0);
                chk("rel_pend", 32'(pending), 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
